// File: rtl/sseg_scan_ctrl_pkg.sv
//==============================================================================
// sseg_scan_ctrl_pkg : shared constants and types for the 7-segment scan block
// Revision 1.0
//==============================================================================
`default_nettype none

package sseg_scan_ctrl_pkg;

    // Segment vectors are ordered a..g, active-low.
    typedef logic [0:6] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_DASH  = 7'b1111110;

    typedef enum logic [0:0] {
        S_GUARD = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sseg_scan_ctrl_bcdtosseg.sv
//==============================================================================
// BCDtoSSeg : BCD nibble to active-low a..g segment pattern, dash for 10..15
// Revision 1.0
//==============================================================================
`default_nettype none

module BCDtoSSeg
    import sseg_scan_ctrl_pkg::*;
(
    input  logic [3:0] bcd_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = 7'b0000001;
            4'd1:    seg_o = 7'b1001111;
            4'd2:    seg_o = 7'b0010010;
            4'd3:    seg_o = 7'b0000110;
            4'd4:    seg_o = 7'b1001100;
            4'd5:    seg_o = 7'b0100100;
            4'd6:    seg_o = 7'b0100000;
            4'd7:    seg_o = 7'b0001111;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0000100;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
//==============================================================================
// sseg_scan_ctrl : time-multiplexed N-digit common-anode 7-segment scanner
// Revision 1.0
//==============================================================================
`default_nettype none

module sseg_scan_ctrl
    import sseg_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic                  blank_lz,
    output logic                  load_ack,
    output logic                  frame,
    output logic [0:6]            SSeg,
    output logic [N_DIGITS-1:0]   an
);

    localparam int SLOT  = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int BCD_W = 4 * N_DIGITS;

    localparam logic [N_DIGITS-1:0] AN_OFF   = '1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SLOT - 1);
    localparam logic [CNT_W-1:0]    CNT_GRD  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);

    state_t                state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic [BCD_W-1:0]      shadow_q,  shadow_d;
    logic [BCD_W-1:0]      disp_q,    disp_d;
    logic                  pending_q, pending_d;
    logic                  lz_q,      lz_d;
    logic                  ack_q,     ack_d;
    logic                  frame_q,   frame_d;
    logic [N_DIGITS-1:0]   an_q,      an_d;
    seg_t                  seg_q,     seg_d;

    logic [3:0]            digits   [N_DIGITS];
    logic [N_DIGITS-1:0]   zero_up;
    logic [3:0]            digit_sel;
    seg_t                  dec_seg;
    logic                  cnt_last;
    logic                  boundary;
    logic                  blank_digit;

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digits
            assign digits[gi] = disp_q[4*gi +: 4];
        end
    endgenerate

    // zero_up[i] = 1 when every digit from N-1 down to i is zero.
    always_comb begin
        zero_up = '0;
        zero_up[N_DIGITS-1] = (digits[N_DIGITS-1] == 4'd0);
        for (int i = N_DIGITS - 2; i >= 0; i--) begin
            zero_up[i] = zero_up[i+1] && (digits[i] == 4'd0);
        end
    end

    assign digit_sel = digits[idx_q];

    BCDtoSSeg u_dec (
        .bcd_i (digit_sel),
        .seg_o (dec_seg)
    );

    assign cnt_last    = (cnt_q == CNT_LAST);
    assign boundary    = (state_q == S_SHOW) && cnt_last && (idx_q == IDX_LAST);
    assign blank_digit = lz_q && (idx_q != '0) && zero_up[idx_q];

    // Prescaler, scan FSM and digit index.
    always_comb begin
        cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        idx_d   = idx_q;
        lz_d    = lz_q;
        case (state_q)
            S_GUARD: begin
                if (cnt_q == CNT_GRD) begin
                    state_d = S_SHOW;
                    lz_d    = blank_lz;
                end
            end
            S_SHOW: begin
                if (cnt_last) begin
                    state_d = S_GUARD;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_GUARD;
            end
        endcase
    end

    // Shadow register and frame-aligned commit; a load on the boundary bypasses the shadow.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        disp_d    = disp_q;
        ack_d     = 1'b0;
        frame_d   = boundary;
        if (boundary) begin
            if (load) begin
                shadow_d  = bcd_in;
                disp_d    = bcd_in;
                pending_d = 1'b0;
                ack_d     = 1'b1;
            end else if (pending_q) begin
                disp_d    = shadow_q;
                pending_d = 1'b0;
                ack_d     = 1'b1;
            end
        end else if (load) begin
            shadow_d  = bcd_in;
            pending_d = 1'b1;
        end
    end

    // Anode and segment pins are both derived from the same state/idx, so they move together.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (state_q == S_SHOW) begin
            an_d  = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q);
            seg_d = blank_digit ? SEG_BLANK : dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_GUARD;
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            lz_q      <= 1'b0;
            ack_q     <= 1'b0;
            frame_q   <= 1'b0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            lz_q      <= lz_d;
            ack_q     <= ack_d;
            frame_q   <= frame_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign load_ack = ack_q;
    assign frame    = frame_q;
    assign SSeg     = seg_q;
    assign an       = an_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
//==============================================================================
// tb_sseg_scan_ctrl : scoreboard bench for sseg_scan_ctrl (SLOT=10, guard=2, 4 digits)
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_sseg_scan_ctrl;

    localparam int N     = 4;
    localparam int SLOT  = 10;
    localparam int BLANK = 2;
    localparam int FRAME = N * SLOT;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [15:0]   bcd_in;
    logic          blank_lz;
    logic          load_ack;
    logic          frame;
    logic [0:6]    SSeg;
    logic [3:0]    an;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            k        = 0;
    logic [27:0]   sb_q [$];
    logic [27:0]   cur_exp;
    logic          ack_exp;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(
        .N_DIGITS     (N),
        .CLK_HZ       (1000),
        .SCAN_HZ      (100),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .bcd_in   (bcd_in),
        .blank_lz (blank_lz),
        .load_ack (load_ack),
        .frame    (frame),
        .SSeg     (SSeg),
        .an       (an)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s k=%0d: got %0h, expected %0h", tag, k, obs, exp);
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111110;
        endcase
    endfunction

    // Expected segment pattern of each digit for a committed value, digit i at bits [7i+:7].
    function automatic logic [27:0] frame_pat(input logic [15:0] v, input logic lz);
        logic [27:0] p;
        logic        z;
        logic [3:0]  nib;
        p = '0;
        z = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            nib = v[4*i +: 4];
            z   = z && (nib == 4'd0);
            if (lz && i >= 1 && z) p[7*i +: 7] = 7'b1111111;
            else                   p[7*i +: 7] = seg_of(nib);
        end
        return p;
    endfunction

    // One clock: sample outputs mid-cycle and compare to the scan timeline and scoreboard.
    task automatic tick();
        int          off;
        int          dig;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        bnd;
        @(negedge clk);
        k++;
        off = (k - 1) % SLOT;
        dig = ((k - 1) / SLOT) % N;
        if (((k - 1) % FRAME) == BLANK && sb_q.size() > 0) cur_exp = sb_q.pop_front();
        if (off < BLANK) begin
            e_an  = 4'b1111;
            e_seg = 7'b1111111;
        end else begin
            e_an  = 4'b0001 << dig;
            e_an  = ~e_an;
            e_seg = cur_exp[7*dig +: 7];
        end
        check("an", 32'(an), 32'(e_an));
        check("sseg", 32'(SSeg), 32'(e_seg));
        bnd = ((k % FRAME) == 0);
        check("frame", 32'(frame), 32'(bnd));
        check("load_ack", 32'(load_ack), 32'(bnd & ack_exp));
        if (bnd) ack_exp = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    task automatic do_load(input logic [15:0] v);
        load   = 1'b1;
        bcd_in = v;
        tick();
        load   = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_an", 32'(an), 32'hF);
        check("rst_sseg", 32'(SSeg), 32'h7F);
        check("rst_ack", 32'(load_ack), 32'h0);
        check("rst_frame", 32'(frame), 32'h0);
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        bcd_in   = '0;
        blank_lz = 1'b0;
        ack_exp  = 1'b0;
        cur_exp  = frame_pat(16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        k   = 0;

        // Free-run: zeros on every digit with guard gaps.
        run_to(40);

        // Mid-frame load commits at the next frame boundary.
        run_to(54);
        sb_q.push_back(frame_pat(16'h1234, 1'b0));
        ack_exp = 1'b1;
        do_load(16'h1234);

        // Boundary-cycle bypass loads with leading-zero blanking.
        run_to(119);
        blank_lz = 1'b1;
        sb_q.push_back(frame_pat(16'h0050, 1'b1));
        ack_exp = 1'b1;
        do_load(16'h0050);
        run_to(159);
        sb_q.push_back(frame_pat(16'h0000, 1'b1));
        ack_exp = 1'b1;
        do_load(16'h0000);

        // Non-BCD nibble in digit 2 shows a dash.
        run_to(199);
        blank_lz = 1'b0;
        sb_q.push_back(frame_pat(16'h3A21, 1'b0));
        ack_exp = 1'b1;
        do_load(16'h3A21);

        // Two pending loads then a boundary load: one ack, last value wins.
        run_to(209);
        do_load(16'h1111);
        run_to(219);
        do_load(16'h9999);
        run_to(239);
        sb_q.push_back(frame_pat(16'h4321, 1'b0));
        ack_exp = 1'b1;
        do_load(16'h4321);
        run_to(320);

        // Reset during digit 2 with a load pending: load discarded, display cleared.
        run_to(329);
        sb_q.push_back(frame_pat(16'h5555, 1'b0));
        ack_exp = 1'b1;
        do_load(16'h5555);
        run_to(345);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst     = 1'b0;
        k       = 0;
        sb_q.delete();
        ack_exp = 1'b0;
        cur_exp = frame_pat(16'h0000, 1'b0);
        run_to(45);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
